pwm_synth_voice: RTL

- Parametrised single-voice audio synthesiser that drives the Nexys A7 mono PWM amplifier pin.
- Uses a DDS phase accumulator with a tuning word instead of a divider.
- Supports selectable sawtooth, square or triangle waveforms, with an attack/sustain/release amplitude envelope.
- Configuration changes are handshaked and applied only on PWM period boundaries, so switching is glitch-free. The block sits between the note/control logic and the AUD_PWM/AUD_SD pins.

---
 rtl/pwm_synth_voice.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/pwm_synth_voice.sv
// -----------------------------------------------------------------------------
// pwm_synth_voice
//   Single-voice audio synthesiser for a mono PWM amplifier pin.
//   A DDS phase accumulator produces a saw, square or triangle wave. The wave is
//   scaled by an attack/sustain/release envelope and the result is emitted as a
//   PWM duty cycle. Configuration arrives through a valid/ready handshake. It is
//   parked in a one-entry pending slot and applied only on a PWM period
//   boundary, so waveform and frequency changes never cut a period short.
//
// Ports
//   clk        system clock (single clock domain)
//   reset      synchronous, active-high reset
//   gate       note on (1) / note off (0), sampled on period boundaries
//   cfg_valid  configuration request
//   cfg_ready  pending slot is free (registered)
//   cfg_freq   DDS tuning word; 0 holds the phase
//   cfg_mode   00 saw, 01 square, 10 triangle, 11 silent
//   pwm_out    registered PWM audio output (AUD_PWM)
//   amp_en     amplifier enable (AUD_SD), high whenever the envelope is active
//   env_state  00 IDLE, 01 ATTACK, 10 SUSTAIN, 11 RELEASE
// -----------------------------------------------------------------------------
module pwm_synth_voice #(
  parameter int PWM_BITS     = 8,
  parameter int PHASE_BITS   = 24,
  parameter int CLK_DIV      = 4,
  parameter int ATTACK_STEP  = 8,
  parameter int RELEASE_STEP = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  gate,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [PHASE_BITS-1:0] cfg_freq,
  input  logic [1:0]            cfg_mode,
  output logic                  pwm_out,
  output logic                  amp_en,
  output logic [1:0]            env_state
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]    DIV_LAST    = DIV_W'(CLK_DIV - 1);
  localparam logic [PWM_BITS-1:0] ENV_MAX     = '1;
  localparam logic [PWM_BITS:0]   ATTACK_INC  = (PWM_BITS + 1)'(ATTACK_STEP);
  localparam logic [PWM_BITS:0]   RELEASE_DEC = (PWM_BITS + 1)'(RELEASE_STEP);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ATTACK  = 2'b01,
    SUSTAIN = 2'b10,
    RELEASE = 2'b11
  } env_state_e;

  typedef enum logic [1:0] {
    MODE_SAW      = 2'b00,
    MODE_SQUARE   = 2'b01,
    MODE_TRIANGLE = 2'b10,
    MODE_SILENT   = 2'b11
  } wave_mode_e;

  // Timebase and voice state
  logic [DIV_W-1:0]      div_cnt;
  logic [PWM_BITS-1:0]   pwm_cnt;
  logic [PHASE_BITS-1:0] phase;
  logic [PHASE_BITS-1:0] freq_word;
  wave_mode_e            mode;
  logic [PWM_BITS-1:0]   duty;
  logic [PWM_BITS-1:0]   env;
  env_state_e            state;

  // One-entry configuration slot
  logic                  pending_full;
  logic [PHASE_BITS-1:0] pending_freq;
  wave_mode_e            pending_mode;

  logic tick;
  logic boundary;
  logic transfer;

  assign tick     = (div_cnt == DIV_LAST);
  assign boundary = tick && (&pwm_cnt);
  assign transfer = cfg_valid && cfg_ready;

  assign amp_en    = (state != IDLE);
  assign env_state = state;

  // ---------------------------------------------------------------------------
  // Waveform generation and envelope scaling
  // ---------------------------------------------------------------------------
  logic [PWM_BITS-1:0] phase_top;
  logic [PWM_BITS-1:0] tri_base;
  logic [PWM_BITS-1:0] wave;
  logic [PWM_BITS-1:0] sample;

  always_comb begin
    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    wave      = '0;
    phase_top = phase[PHASE_BITS-1 -: PWM_BITS];
    // Triangle rises over the first half-cycle at twice the saw slope, then
    // mirrors itself over the second half.
    tri_base  = {phase_top[PWM_BITS-2:0], 1'b0};
    unique case (mode)
      MODE_SAW:      wave = phase_top;
      MODE_SQUARE:   wave = phase[PHASE_BITS-1] ? '0 : ENV_MAX;
      MODE_TRIANGLE: wave = phase[PHASE_BITS-1] ? ~tri_base : tri_base;
      MODE_SILENT:   wave = '0;
      default:       wave = '0;
    endcase
  end

  // Unsigned full-width product, upper half kept as the next duty value.
  assign sample = PWM_BITS'(({{PWM_BITS{1'b0}}, wave} * {{PWM_BITS{1'b0}}, env}) >> PWM_BITS);

  // ---------------------------------------------------------------------------
  // Envelope next-state. A gate-driven transition holds env for that step, so
  // a retrigger continues from the current level.
  // ---------------------------------------------------------------------------
  logic [PWM_BITS:0]   env_sum;
  logic [PWM_BITS-1:0] env_next;
  env_state_e          state_next;

  assign env_sum = {1'b0, env} + ATTACK_INC;

  always_comb begin
    env_next   = env;
    state_next = state;
    unique case (state)
      IDLE: begin
        env_next = '0;
        if (gate) state_next = ATTACK;
      end
      ATTACK: begin
        if (!gate) begin
          state_next = RELEASE;
        end else if (env_sum >= {1'b0, ENV_MAX}) begin
          env_next   = ENV_MAX;
          state_next = SUSTAIN;
        end else begin
          env_next = env_sum[PWM_BITS-1:0];
        end
      end
      SUSTAIN: begin
        env_next = ENV_MAX;
        if (!gate) state_next = RELEASE;
      end
      RELEASE: begin
        if (gate) begin
          state_next = ATTACK;
        end else if ({1'b0, env} <= RELEASE_DEC) begin
          env_next   = '0;
          state_next = IDLE;
        end else begin
          env_next = env - RELEASE_DEC[PWM_BITS-1:0];
        end
      end
      default: begin
        env_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, which is what the boundary update relies on.
    if (reset) begin
      div_cnt      <= '0;
      pwm_cnt      <= '0;
      phase        <= '0;
      freq_word    <= '0;
      mode         <= MODE_SILENT;
      duty         <= '0;
      env          <= '0;
      state        <= IDLE;
      pending_full <= 1'b0;
      cfg_ready    <= 1'b1;
      pwm_out      <= 1'b0;
      // NOTE: the pending payload is deliberately not reset; pending_full qualifies it.
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;

      pwm_out <= (pwm_cnt < duty);

      if (boundary) begin
        duty  <= sample;
        phase <= phase + freq_word;
        env   <= env_next;
        state <= state_next;
        // Phase is left running so a frequency change stays phase-continuous.
        if (pending_full) begin
          freq_word    <= pending_freq;
          mode         <= pending_mode;
          pending_full <= 1'b0;
          cfg_ready    <= 1'b1;
        end
      end

      // cfg_ready is low whenever the slot is full, so a transfer can never
      // collide with the slot being drained on the same edge.
      if (transfer) begin
        pending_freq <= cfg_freq;
        pending_mode <= wave_mode_e'(cfg_mode);
        pending_full <= 1'b1;
        cfg_ready    <= 1'b0;
      end
    end
  end

endmodule
